// File: rtl/bpu_pkg.sv
// bpu_pkg: shared definitions for the branch prediction unit.
//   - bcuop width and the 3-bit branch compare encodings
//   - 2-bit counter state constants and the counter reset value
//   - helpers for counter update and branch-direction decode
// Configuration macro used by the unit: BPU_GSHARE_EN (see rtl/bpu.sv).
package bpu_pkg;

    localparam int BCUOP_LENGTH = 3;

    typedef enum logic [BCUOP_LENGTH-1:0] {
        BCUOP_NONE = 3'b000,
        BCUOP_BEQ  = 3'b001,
        BCUOP_BGE  = 3'b010,
        BCUOP_BGEU = 3'b011,
        BCUOP_BLT  = 3'b100,
        BCUOP_BLTU = 3'b101,
        BCUOP_BNE  = 3'b110,
        BCUOP_RSVD = 3'b111
    } bcuop_e;

    typedef logic [1:0] bpu_cnt_t;

    localparam bpu_cnt_t BPU_SNT       = 2'b00;
    localparam bpu_cnt_t BPU_WNT       = 2'b01;
    localparam bpu_cnt_t BPU_WT        = 2'b10;
    localparam bpu_cnt_t BPU_ST        = 2'b11;
    localparam bpu_cnt_t BPU_CNT_RESET = BPU_WNT;

    // Saturating step of a 2-bit counter toward the resolved direction.
    function automatic bpu_cnt_t sat_step(input bpu_cnt_t cnt, input logic taken);
        bpu_cnt_t nxt;
        nxt = cnt;
        if (taken && cnt != BPU_ST)
            nxt = cnt + 2'd1;
        else if (!taken && cnt != BPU_SNT)
            nxt = cnt - 2'd1;
        return nxt;
    endfunction

    // True for the six real compare ops; none and reserved are not branches.
    function automatic logic is_branch(input bcuop_e op);
        return (op != BCUOP_NONE) && (op != BCUOP_RSVD);
    endfunction

    function automatic logic branch_taken(input bcuop_e op, input logic lt,
                                          input logic ltu, input logic zero);
        logic taken;
        case (op)
            BCUOP_BEQ:  taken = zero;
            BCUOP_BNE:  taken = ~zero;
            BCUOP_BLT:  taken = lt;
            BCUOP_BGE:  taken = ~lt;
            BCUOP_BLTU: taken = ltu;
            BCUOP_BGEU: taken = ~ltu;
            default:    taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/bpu_if.sv
// bpu_if: fetch-side predict bus and execute-side resolve bus of the bpu.
//   master : fetch/execute pipeline (drives queries and resolves)
//   slave  : the bpu (returns predictions, redirect and statistics)
// There is no handshake: every input is sampled when its valid bit is 1,
// prediction outputs are combinational, redirect_o_bpu is a one-cycle pulse.
interface bpu_if #(
    parameter int XLEN = 64,
    parameter int IDXW = 6
);
    logic            pd_valid_i_bpu;
    logic [XLEN-1:0] pd_pc_i_bpu;
    logic [XLEN-1:0] pd_offset_i_bpu;
    logic            pred_taken_o_bpu;
    logic [XLEN-1:0] pred_dnpc_o_bpu;
    logic [IDXW-1:0] pred_idx_o_bpu;

    logic            ex_valid_i_bpu;
    logic [2:0]      ex_bcuop_i_bpu;
    logic            ex_lt_i_bpu;
    logic            ex_ltu_i_bpu;
    logic            ex_zero_i_bpu;
    logic [XLEN-1:0] ex_pc_i_bpu;
    logic [XLEN-1:0] ex_offset_i_bpu;
    logic            ex_pred_taken_i_bpu;
    logic [IDXW-1:0] ex_pred_idx_i_bpu;

    logic            redirect_o_bpu;
    logic [XLEN-1:0] redirect_pc_o_bpu;
    logic [31:0]     br_cnt_o_bpu;
    logic [31:0]     mis_cnt_o_bpu;

    modport master (
        output pd_valid_i_bpu, pd_pc_i_bpu, pd_offset_i_bpu,
        input  pred_taken_o_bpu, pred_dnpc_o_bpu, pred_idx_o_bpu,
        output ex_valid_i_bpu, ex_bcuop_i_bpu, ex_lt_i_bpu, ex_ltu_i_bpu,
               ex_zero_i_bpu, ex_pc_i_bpu, ex_offset_i_bpu,
               ex_pred_taken_i_bpu, ex_pred_idx_i_bpu,
        input  redirect_o_bpu, redirect_pc_o_bpu, br_cnt_o_bpu, mis_cnt_o_bpu
    );

    modport slave (
        input  pd_valid_i_bpu, pd_pc_i_bpu, pd_offset_i_bpu,
        output pred_taken_o_bpu, pred_dnpc_o_bpu, pred_idx_o_bpu,
        input  ex_valid_i_bpu, ex_bcuop_i_bpu, ex_lt_i_bpu, ex_ltu_i_bpu,
               ex_zero_i_bpu, ex_pc_i_bpu, ex_offset_i_bpu,
               ex_pred_taken_i_bpu, ex_pred_idx_i_bpu,
        output redirect_o_bpu, redirect_pc_o_bpu, br_cnt_o_bpu, mis_cnt_o_bpu
    );
endinterface

// File: rtl/bpu_bht.sv
// bpu_bht: table of 2-bit saturating counters.
// Ports:
//   clk, rst_n      clock, async active-low reset (all entries -> weakly not-taken)
//   rd_idx/rd_taken async read port; returns the counter's direction bit
//   wr_en/wr_idx/wr_taken  saturating increment (taken) or decrement
// A read and write of the same entry in one cycle returns the old value.
module bpu_bht
    import bpu_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDXW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IDXW-1:0] rd_idx,
    output logic            rd_taken,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  logic            wr_taken
);

    bpu_cnt_t cnt_q [DEPTH];

    assign rd_taken = cnt_q[rd_idx][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                cnt_q[i] <= BPU_CNT_RESET;
        end else if (wr_en) begin
            cnt_q[wr_idx] <= sat_step(cnt_q[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/bpu.sv
// bpu: branch prediction and resolution unit.
// Ports:
//   clk_i_bpu    clock, rising edge
//   rst_n_i_bpu  asynchronous active-low reset
//   bus          bpu_if.slave: fetch predict path, execute resolve path,
//                registered redirect and resolve/mispredict statistics
// Prediction is combinational from the counter table. A resolve (valid execute
// slot with a real compare op) trains the carried index, and a mispredict
// raises redirect on the following cycle with the correct next PC.
// Optional macro BPU_GSHARE_EN: XOR the fetch index with a global history
// register updated on every resolve; otherwise the table is indexed bimodally.
module bpu
    import bpu_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int BHT_DEPTH = 64,
    parameter int IDXW      = $clog2(BHT_DEPTH)
) (
    input  logic clk_i_bpu,
    input  logic rst_n_i_bpu,
    bpu_if.slave bus
);

    logic [IDXW-1:0] pred_idx;
    logic            bht_taken;
    logic            resolve;
    logic            actual;
    logic            mispredict;
    logic [XLEN-1:0] correct_pc;
    bcuop_e          op;

    logic            redirect_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic [31:0]     br_cnt_q;
    logic [31:0]     mis_cnt_q;

`ifdef BPU_GSHARE_EN
    // History holds resolved directions only, so it lags speculative fetch.
    logic [IDXW-1:0] ghr_q;

    assign pred_idx = bus.pd_pc_i_bpu[IDXW+1:2] ^ ghr_q;

    always_ff @(posedge clk_i_bpu or negedge rst_n_i_bpu) begin
        if (!rst_n_i_bpu)
            ghr_q <= '0;
        else if (resolve)
            ghr_q <= {ghr_q[IDXW-2:0], actual};
    end
`else
    assign pred_idx = bus.pd_pc_i_bpu[IDXW+1:2];
`endif

    bpu_bht #(
        .DEPTH (BHT_DEPTH),
        .IDXW  (IDXW)
    ) u_bht (
        .clk      (clk_i_bpu),
        .rst_n    (rst_n_i_bpu),
        .rd_idx   (pred_idx),
        .rd_taken (bht_taken),
        .wr_en    (resolve),
        .wr_idx   (bus.ex_pred_idx_i_bpu),
        .wr_taken (actual)
    );

    // Predict path
    assign bus.pred_idx_o_bpu   = pred_idx;
    assign bus.pred_taken_o_bpu = bus.pd_valid_i_bpu & bht_taken;
    assign bus.pred_dnpc_o_bpu  = bus.pred_taken_o_bpu
                                ? bus.pd_pc_i_bpu + bus.pd_offset_i_bpu
                                : bus.pd_pc_i_bpu + XLEN'(4);

    // Resolve path
    assign op         = bcuop_e'(bus.ex_bcuop_i_bpu);
    assign resolve    = bus.ex_valid_i_bpu & is_branch(op);
    assign actual     = branch_taken(op, bus.ex_lt_i_bpu, bus.ex_ltu_i_bpu,
                                     bus.ex_zero_i_bpu);
    assign mispredict = resolve & (actual != bus.ex_pred_taken_i_bpu);
    assign correct_pc = actual ? bus.ex_pc_i_bpu + bus.ex_offset_i_bpu
                               : bus.ex_pc_i_bpu + XLEN'(4);

    always_ff @(posedge clk_i_bpu or negedge rst_n_i_bpu) begin
        if (!rst_n_i_bpu) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            br_cnt_q      <= '0;
            mis_cnt_q     <= '0;
        end else begin
            redirect_q <= mispredict;
            if (mispredict)
                redirect_pc_q <= correct_pc;
            if (resolve && br_cnt_q != 32'hFFFF_FFFF)
                br_cnt_q <= br_cnt_q + 32'd1;
            if (mispredict && mis_cnt_q != 32'hFFFF_FFFF)
                mis_cnt_q <= mis_cnt_q + 32'd1;
        end
    end

    assign bus.redirect_o_bpu    = redirect_q;
    assign bus.redirect_pc_o_bpu = redirect_pc_q;
    assign bus.br_cnt_o_bpu      = br_cnt_q;
    assign bus.mis_cnt_o_bpu     = mis_cnt_q;

endmodule
